// File: rtl/voice_allocator.sv
// Note-on/note-off voice allocator driving NUM_VOICES tone generators (2-cycle note-on latency).
// Optional macro VOICE_STEAL_EN: when all voices are gated, steal the oldest instead of dropping.
module voice_allocator #(
    parameter int          NUM_VOICES = 4,
    parameter logic [15:0] FREQ_MIN   = 16'd20
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       on_valid,
    output logic                       on_ready,
    input  logic [6:0]                 on_note,
    input  logic [15:0]                on_freq,
    input  logic                       off_valid,
    input  logic [6:0]                 off_note,
    output logic [16*NUM_VOICES-1:0]   voice_freq,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [NUM_VOICES-1:0]      voice_restart,
    output logic                       drop
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic {IDLE, ALLOC} state_t;

    state_t state, state_next;

    logic [6:0]            lat_note;
    logic [15:0]           lat_freq;
    logic [15:0]           freq_q [NUM_VOICES];
    logic [6:0]            note_q [NUM_VOICES];
    logic [7:0]            age_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;

    logic [NUM_VOICES-1:0] off_match;
    logic [NUM_VOICES-1:0] gate_after_off;
    logic                  hit_valid, free_valid, sel_valid;
    logic [IDX_W-1:0]      hit_idx, free_idx, old_idx, sel_idx;
    logic [7:0]            old_age;
    logic [15:0]           new_freq;

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (on_valid) state_next = ALLOC;
            ALLOC:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        on_ready = (state == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_note <= '0;
            lat_freq <= '0;
        end else if (on_valid && on_ready) begin
            lat_note <= on_note;
            lat_freq <= on_freq;
        end
    end

    // A coincident note-off is applied before selection, so a voice it frees is reusable at once.
    always_comb begin
        off_match      = '0;
        hit_valid      = 1'b0;
        hit_idx        = '0;
        free_valid     = 1'b0;
        free_idx       = '0;
        old_idx        = '0;
        old_age        = age_q[0];
        sel_valid      = 1'b0;
        sel_idx        = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            off_match[i] = off_valid && gate_q[i] && (note_q[i] == off_note);
        gate_after_off = gate_q & ~off_match;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_after_off[i] && note_q[i] == lat_note) begin
                hit_valid = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (!gate_after_off[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        // Strict compare keeps the lowest index on equal ages.
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IDX_W'(i);
            end
        end
        if (hit_valid) begin
            sel_valid = 1'b1;
            sel_idx   = hit_idx;
        end else if (free_valid) begin
            sel_valid = 1'b1;
            sel_idx   = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
            sel_valid = 1'b1;
            sel_idx   = old_idx;
`else
            sel_valid = 1'b0;
            sel_idx   = '0;
`endif
        end
        new_freq = (lat_freq < FREQ_MIN) ? FREQ_MIN : lat_freq;
    end

    // NOTE: voice state is a handful of registers, not a RAM, so it is reset like any other flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gate_q        <= '0;
            voice_restart <= '0;
            drop          <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i] <= FREQ_MIN;
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            voice_restart <= '0;
            drop          <= 1'b0;
            gate_q        <= gate_after_off;
            if (state == ALLOC) begin
                if (sel_valid) begin
                    gate_q[sel_idx]        <= 1'b1;
                    freq_q[sel_idx]        <= new_freq;
                    note_q[sel_idx]        <= lat_note;
                    voice_restart[sel_idx] <= 1'b1;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (i == int'(sel_idx))    age_q[i] <= '0;
                        else if (age_q[i] != 8'hFF) age_q[i] <= age_q[i] + 8'd1;
                    end
                end else begin
                    drop <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        voice_gate = gate_q;
        for (int i = 0; i < NUM_VOICES; i++)
            voice_freq[16*i +: 16] = freq_q[i];
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4, meaning the number of tone-generator voices driven (range 2..8).
REQ-002 The block SHALL have parameter FREQ_MIN, default 16'd20, meaning the lowest frequency code ever driven to a voice, so a generator never divides by zero.
REQ-003 The block SHALL have port clock  input  1  system clock, all state on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port on_valid  input  1  note-on request present.
REQ-006 The block SHALL have port on_ready  output  1  note-on request can be accepted.
REQ-007 The block SHALL have port on_note  input  7  note number of the note-on.
REQ-008 The block SHALL have port on_freq  input  16  frequency code of the note-on.
REQ-009 The block SHALL have port off_valid  input  1  single-cycle note-off strobe (no handshake).
REQ-010 The block SHALL have port off_note  input  7  note number of the note-off.
REQ-011 The block SHALL have port voice_freq  output  16*NUM_VOICES  per-voice frequency code, with voice i at bits [16i+15:16i].
REQ-012 The block SHALL have port voice_gate  output  NUM_VOICES  per-voice gate, 1 = sounding.
REQ-013 The block SHALL have port voice_restart  output  NUM_VOICES  one-cycle pulse that restarts the phase of a voice.
REQ-014 The block SHALL have port drop  output  1  one-cycle pulse when an accepted note-on was discarded.

Function
REQ-015 The block SHALL run a two-state FSM: IDLE (on_ready=1) and ALLOC (on_ready=0).
REQ-016 The FSM SHALL move IDLE->ALLOC on on_valid&&on_ready, latch on_note/on_freq at that edge, and return ALLOC->IDLE unconditionally after one cycle.
REQ-017 When a note-on is accepted at edge T, the resulting voice_gate/voice_freq update and the voice_restart pulse SHALL be visible in the cycle following edge T+1, so the latency is 2 cycles.
REQ-018 Selection SHALL follow this order: (1) a gated voice already holding the same note is retriggered; (2) otherwise the lowest-index ungated voice is used; (3) otherwise the full case of REQ-029/030 applies.
REQ-019 The selected voice SHALL get gate=1, freq=max(latched freq, FREQ_MIN) and note=latched note, and its voice_restart SHALL pulse for exactly one cycle.
REQ-020 Each voice SHALL have an 8-bit age counter; on every allocation the selected voice's age SHALL be cleared to 0 and the other voices' ages SHALL increment, saturating at 255.
REQ-021 off_valid SHALL be honoured in any state and SHALL clear the gate of every gated voice whose note equals off_note, visible after the next edge.
REQ-022 A note-off SHALL leave voice_freq unchanged, so the frequency is held for release.
REQ-023 When off_valid coincides with the ALLOC cycle for the same note, the note-off SHALL apply first, the allocation SHALL then see that voice as free, and the final gate SHALL be 1.
REQ-024 A note-off with no matching voice SHALL have no effect.
REQ-025 A note-on with on_freq=0 SHALL drive FREQ_MIN to the voice.
REQ-026 on_note/on_freq SHALL be ignored whenever on_valid is low or on_ready is low.

Reset
REQ-027 While reset is high: state=IDLE, on_ready=1, all voice_gate=0, all voice_freq=FREQ_MIN, stored notes=0, ages=0, voice_restart=0, drop=0.
REQ-028 Reset asserted during ALLOC SHALL abort the allocation, and no gate SHALL change after reset is released.

Configuration
REQ-029 With macro VOICE_STEAL_EN defined, a note-on when all voices are gated SHALL steal the voice with the largest age (ties go to the lowest index) and apply REQ-019; drop SHALL stay 0.
REQ-030 Without VOICE_STEAL_EN, that note-on SHALL leave all voices unchanged, leave ages unchanged, and pulse drop for one cycle at the same time a gate update would otherwise occur.

Verification
REQ-031 Scenario 1: after reset, note-on note=60 freq=440 -> voice0 gate=1, freq=440, restart pulse 2 cycles after acceptance; on_ready low for 1 cycle.
REQ-032 Scenario 2: note-ons 60, 64, 67, 72, then note-off 64 -> gates 1111 then 1101; voice1 freq stays at its value.
REQ-033 Scenario 3: a fifth note-on 76 with 4 voices gated -> with VOICE_STEAL_EN, voice0 (the oldest) gets 76 and restarts; without it, drop pulses and the gates stay 1111.
REQ-034 Scenario 4: repeated note-on 60 while 60 is gated on voice0 -> voice0 is retriggered, no other voice changes, voice0 age=0.
REQ-035 Scenario 5: note-on freq=0 -> voice freq=20; reset asserted during the ALLOC cycle -> all gates 0, state IDLE, no restart pulse.
